// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, 2-flop synchronized input, mid-bit sampling.
// Delivers each good byte as a one-cycle rvalid pulse; bad stop bits raise frame_err.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic             rxd_meta;
    logic             rxd_s;
    logic             rxd_prev;
    logic             fall;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    // Flops reset to the idle line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    assign fall = rxd_prev & ~rxd_s;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rvalid    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        clk_cnt <= '0;
                    end
                end
                START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= rxd_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rxd_s, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (rxd_s) begin
                            rdata  <= shift;
                            rvalid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
